// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Drives the pipeline-wide hit/advance signal and a registered req/ack port to main memory.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES][WORDS];

  logic [OFF_W-1:0]   offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;
  logic               ack_live;
  logic               data_we;
  logic               tag_we;
  logic [OFF_W-1:0]   data_off;
  logic [31:0]        data_wval;
  logic               unused_addr_bits;

  assign offset           = addr[OFF_W+1:2];
  assign index            = addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag              = addr[31:OFF_W+IDX_W+2];
  assign unused_addr_bits = ^addr[1:0];
  assign lookup_hit       = valid_q[index] && (tag_mem[index] == tag);
  // An ack with no outstanding request is a stray pulse and must not move anything.
  assign ack_live         = mem_ack && mem_req_q;

  assign read_data = data_mem[index][offset];
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[index][data_off] <= data_wval;
    if (tag_we)  tag_mem[index]            <= tag;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = valid_q;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    data_off    = cnt_q;
    data_wval   = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = write_data;
        end else if (mem_read && !lookup_hit) begin
          state_d    = REFILL;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag, index, {OFF_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        if (ack_live) begin
          data_we    = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          mem_addr_d = {tag, index, cnt_d, 2'b00};
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            tag_we         = 1'b1;
            valid_d[index] = 1'b1;
            mem_req_d      = 1'b0;
            state_d        = IDLE;
          end
        end
      end
      WRITE: begin
        if (ack_live) begin
          if (lookup_hit) begin
            data_we   = 1'b1;
            data_off  = offset;
            data_wval = write_data;
          end
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (mem_write)     hit = 1'b0;
        else if (mem_read) hit = lookup_hit;
      end
      REFILL:  hit = 1'b0;
      WRITE:   hit = ack_live;
      default: hit = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a small memory responder task plus hand-computed expectations.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Waits for mem_req, records the transaction, acks `lat` cycles after req is first seen.
  // Returns at the negedge that follows the ack cycle, with mem_ack already dropped.
  task automatic serve(input string tag, input int lat, input logic [31:0] rdata,
                       output logic [31:0] a, output logic we, output logic [31:0] wd,
                       output logic leak, output logic hit_ack);
    int budget;
    budget  = 0;
    leak    = 1'b0;
    a       = 'x;
    we      = 1'bx;
    wd      = 'x;
    hit_ack = 1'bx;
    #1;
    while (!mem_req && budget < 20) begin
      @(negedge clk);
      #1;
      if (hit) leak = 1'b1;
      budget++;
    end
    if (!mem_req) begin
      check1({tag, "_req_timeout"}, mem_req, 1'b1);
    end else begin
      a  = mem_addr;
      we = mem_we;
      wd = mem_wdata;
      if (hit) leak = 1'b1;
      repeat (lat) begin
        @(negedge clk);
        #1;
        if (hit) leak = 1'b1;
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      #1;
      hit_ack = hit;
    end
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic refill_word(input string tag, input int k, input logic [31:0] base,
                             input logic [31:0] dbase, input int lat);
    logic [31:0] a, wd;
    logic        we, leak, ha;
    serve($sformatf("%s_w%0d", tag, k), lat, dbase + 32'(k), a, we, wd, leak, ha);
    check32($sformatf("%s_addr%0d", tag, k), a, base + 32'(4 * k));
    check1($sformatf("%s_we%0d", tag, k), we, 1'b0);
    check1($sformatf("%s_hitlow%0d", tag, k), leak, 1'b0);
    check1($sformatf("%s_hitack%0d", tag, k), ha, 1'b0);
  endtask

  task automatic do_refill(input string tag, input logic [31:0] base,
                           input logic [31:0] dbase, input int lat);
    for (int k = 0; k < 4; k++) refill_word(tag, k, base, dbase, lat);
  endtask

  task automatic do_write(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data, input int lat);
    logic [31:0] a, wd;
    logic        we, leak, ha;
    serve(tag, lat, 32'h0, a, we, wd, leak, ha);
    check32({tag, "_addr"}, a, exp_addr);
    check1({tag, "_we"}, we, 1'b1);
    check32({tag, "_wdata"}, wd, exp_data);
    check1({tag, "_hitlow"}, leak, 1'b0);
    check1({tag, "_hitack"}, ha, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = '0;
    write_data = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_hit", hit, 1'b1);
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_addr", mem_addr, 32'h0);
    check32("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss: four-word refill, 2-cycle ack latency
    mem_read = 1'b1;
    addr     = 32'h40;
    #1;
    check1("miss0_hit", hit, 1'b0);
    check1("miss0_req_lag", mem_req, 1'b0);
    do_refill("rf0", 32'h40, 32'hA0, 2);
    #1;
    check1("rf0_done_hit", hit, 1'b1);
    check32("rf0_data", read_data, 32'hA0);
    check1("rf0_req_drop", mem_req, 1'b0);

    // Read hit on the refilled line
    addr = 32'h48;
    #1;
    check1("rdhit_hit", hit, 1'b1);
    check32("rdhit_data", read_data, 32'hA2);
    @(negedge clk);
    #1;
    check1("rdhit_noreq", mem_req, 1'b0);

    // Write hit, 3-cycle ack latency
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h44;
    write_data = 32'hDEAD_BEEF;
    #1;
    check1("wrhit_req_cycle", hit, 1'b0);
    do_write("wrhit", 32'h44, 32'hDEAD_BEEF, 3);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    #1;
    check1("wrhit_rd_hit", hit, 1'b1);
    check32("wrhit_rd_data", read_data, 32'hDEAD_BEEF);
    check1("wrhit_single_txn", mem_req, 1'b0);

    // Conflict miss on index 4 with a new tag, then the old tag misses again
    addr = 32'h1040;
    #1;
    check1("conf_miss", hit, 1'b0);
    do_refill("rf1", 32'h1040, 32'hB0, 1);
    #1;
    check1("rf1_hit", hit, 1'b1);
    check32("rf1_data", read_data, 32'hB0);
    addr = 32'h40;
    #1;
    check1("evict_miss", hit, 1'b0);
    do_refill("rf2", 32'h40, 32'hC0, 1);
    #1;
    check1("rf2_hit", hit, 1'b1);
    check32("rf2_data", read_data, 32'hC0);

    // Write miss: one memory write, no allocation
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h200;
    write_data = 32'h55AA_55AA;
    #1;
    check1("wrmiss_req_cycle", hit, 1'b0);
    do_write("wrmiss", 32'h200, 32'h55AA_55AA, 1);
    mem_write = 1'b0;
    mem_read  = 1'b1;
    #1;
    check1("no_alloc_miss", hit, 1'b0);
    do_refill("rf3", 32'h200, 32'hD0, 1);
    #1;
    check1("rf3_hit", hit, 1'b1);
    check32("rf3_data", read_data, 32'hD0);

    // Reset after the second ack of a refill
    addr = 32'h1040;
    #1;
    check1("rstmid_miss", hit, 1'b0);
    refill_word("rf5", 0, 32'h1040, 32'hF0, 1);
    refill_word("rf5", 1, 32'h1040, 32'hF0, 1);
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check1("rstmid_req", mem_req, 1'b0);
    check32("rstmid_addr", mem_addr, 32'h0);
    check1("rstmid_hit", hit, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("post_rst_idle_hit", hit, 1'b1);
    mem_read = 1'b1;
    addr     = 32'h40;
    #1;
    check1("post_rst_invalid", hit, 1'b0);
    do_refill("rf4", 32'h40, 32'hE0, 1);
    #1;
    check1("rf4_hit", hit, 1'b1);
    check32("rf4_data", read_data, 32'hE0);

    // Stray ack while idle
    mem_read = 1'b0;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    check1("stray_hit", hit, 1'b1);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1;
    check1("stray_noreq", mem_req, 1'b0);
    mem_read = 1'b1;
    addr     = 32'h4C;
    #1;
    check1("stray_rd_hit", hit, 1'b1);
    check32("stray_rd_data", read_data, 32'hE3);

    // Read and write together: handled as a write hit
    mem_write  = 1'b1;
    addr       = 32'h48;
    write_data = 32'h1234_5678;
    #1;
    check1("dual_hit_low", hit, 1'b0);
    do_write("dual", 32'h48, 32'h1234_5678, 1);
    mem_write = 1'b0;
    #1;
    check1("dual_rd_hit", hit, 1'b1);
    check32("dual_rd_data", read_data, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
